apb_arb_master: RTL and testbench
=================================

# apb_arb_master

Arbitrating APB master: shares a single APB bus (PCLK domain) among `NUM_REQ` internal requesters and sequences each accepted request through the APB SETUP/ACCESS phases. It decodes the address to a one-hot `PSEL`, handles `PREADY` wait states, and returns read data and an error flag to the winning requester. A watchdog aborts hung transfers. It sits between the register-access initiators and the APB slave fabric.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (2..8).
- `NUM_SLV`, default 16: populated `PSEL` lines (1..16).
- `SEL_LSB`, default 12: slave index is `PADDR[SEL_LSB+3:SEL_LSB]`.
- `TIMEOUT`, default 255: maximum ACCESS cycles with `PREADY` low before abort; 0 disables the watchdog.

Ports:
- `PCLK`, input, 1: clock.
- `PRESETn`, input, 1: reset, **synchronous and active-low**.
- `req_valid`, input, NUM_REQ: per-requester request.
- `req_ready`, output, NUM_REQ: one-cycle acceptance pulse, one-hot.
- `req_write`, input, NUM_REQ: 1 = write.
- `req_addr`, input, NUM_REQ*32: packed addresses; requester i uses `[32i+31:32i]`.
- `req_wdata`, input, NUM_REQ*32: packed write data.
- `rsp_valid`, output, NUM_REQ: one-cycle completion pulse, one-hot.
- `rsp_rdata`, output, 32: read data, valid with `rsp_valid`.
- `rsp_err`, output, 1: decode error or timeout, valid with `rsp_valid`.
- `PADDR`, output, 32; `PWDATA`, output, 32; `PWRITE`, output, 1; `PENABLE`, output, 1.
- `PSEL`, output, 16: one-hot slave select; bits at and above `NUM_SLV` are always 0.
- `PRDATA`, input, 32; `PREADY`, input, 1.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any `req_valid` is high, the round-robin winner gets `req_ready` in that cycle, and its addr/wdata/write are latched.
  - If the slave index is below `NUM_SLV`, go to SETUP.
  - Otherwise (decode error), stay in IDLE, with no APB activity. Next cycle: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- SETUP: drive `PSEL[idx]`=1, `PENABLE`=0, plus `PADDR`/`PWRITE`/`PWDATA` from the latch. Go to ACCESS.
- ACCESS:
  - Drive `PENABLE`=1; all other bus signals are held.
  - On `PREADY`=1: capture `PRDATA` (reads only; writes return 0). Next cycle: `rsp_valid`=1, `rsp_err`=0. Go to IDLE.
  - Watchdog: counts ACCESS cycles with `PREADY` low. When it reaches `TIMEOUT`, drop `PSEL`/`PENABLE` and go to IDLE. Next cycle: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- Round-robin: priority starts at the requester after the last granted one. After reset, requester 0 has highest priority. Decode-error grants also advance the pointer.
- Requester rules:
  - Hold `req_*` stable while `req_valid`=1 and `req_ready`=0.
  - At most one outstanding request; do not re-assert `req_valid` before its `rsp_valid`.
- `PADDR`/`PWDATA`/`PWRITE` keep their last values in IDLE. `PSEL`=0 and `PENABLE`=0 in IDLE.

## Timing
- Reset values: all outputs 0, FSM in IDLE, RR pointer at requester 0, watchdog cleared. Reset takes effect at the next `PCLK` edge.
- Reset mid-transfer: the bus drops to idle, and the pending response is discarded (no `rsp_valid`).
- Grant at cycle T: SETUP at T+1, ACCESS from T+2.
  - Zero-wait completion: `PREADY` high at T+2, `rsp_valid` at T+3.
  - The FSM is in IDLE at T+3, so the next grant can occur at T+3 and its SETUP at T+4.
- Each wait state adds exactly one cycle.
- With `TIMEOUT`=N, the abort takes effect after N low-`PREADY` ACCESS cycles. `PENABLE` is high for exactly N cycles.
- `PREADY` is ignored outside ACCESS.

## Structure
- Package `apb_arb_pkg`:
  - State enum `apb_arb_state_e` (IDLE/SETUP/ACCESS).
  - `APB_AW`=32, `APB_DW`=32, `APB_MAX_SLV`=16.
- Sub-module `rr_arbiter`, parameterised by N: inputs `req`, `advance`; outputs one-hot `gnt`. Owns the priority pointer.
- The top level holds the FSM, request latch, decode, watchdog and response register.

## Test plan
- Write, zero wait: req0 writes 0xA5A5_0001 to 0x0000_3010 → `PSEL`=0x0008. SETUP then ACCESS (1 cycle). `rsp_valid[0]` at T+3, `rsp_err`=0.
- Read, 3 wait states: req1 reads 0x0000_1004, slave returns 0xDEAD_BEEF → `PENABLE` high 4 cycles, `rsp_rdata`=0xDEAD_BEEF.
- Contention: req0 and req1 both valid continuously for 4 transfers → grant order 0,1,0,1; at most one APB transfer at a time.
- Decode error: `NUM_SLV`=4, address 0x0000_5000 → `PSEL` stays 0, `rsp_err`=1 the cycle after grant.
- Timeout: `TIMEOUT`=8, `PREADY` held low → `PENABLE` high 8 cycles, then bus idle, `rsp_err`=1, `rsp_rdata`=0.
- Reset mid-ACCESS: `PRESETn` low for 1 cycle → all outputs 0 next edge, no `rsp_valid`, and the next request starts cleanly from IDLE.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and constants for the arbitrating APB master
package apb_arb_pkg;
   localparam int APB_AW      = 32;
   localparam int APB_DW      = 32;
   localparam int APB_MAX_SLV = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves past each taken grant
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d, nxt;
   logic          found;

   // First pass covers requesters at/after the pointer, second pass wraps around.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      nxt   = ptr_q;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && i >= int'(ptr_q)) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
            nxt    = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && i < int'(ptr_q)) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
            nxt    = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
      ptr_d = advance ? nxt : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - shares one APB bus among NUM_REQ requesters
// with address decode, wait-state handling and a hung-transfer watchdog.
module apb_arb_master
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int NUM_SLV = 16,
   parameter int SEL_LSB = 12,
   parameter int TIMEOUT = 255
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*APB_AW-1:0] req_addr,
   input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [APB_DW-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [APB_AW-1:0]         PADDR,
   output logic [APB_DW-1:0]         PWDATA,
   output logic                      PWRITE,
   output logic                      PENABLE,
   output logic [APB_MAX_SLV-1:0]    PSEL,
   input  logic [APB_DW-1:0]         PRDATA,
   input  logic                      PREADY
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [APB_MAX_SLV-1:0] SLV_MASK = APB_MAX_SLV'((32'h1 << NUM_SLV) - 32'h1);

   apb_arb_state_e           state_q, state_d;
   logic [NUM_REQ-1:0]       own_q, own_d, rsp_valid_q, rsp_valid_d, gnt;
   logic [APB_AW-1:0]        paddr_q, paddr_d, win_addr;
   logic [APB_DW-1:0]        pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d, win_wdata;
   logic                     pwrite_q, pwrite_d, penable_q, penable_d, rsp_err_q, rsp_err_d;
   logic                     win_write, grant;
   logic [APB_MAX_SLV-1:0]   psel_q, psel_d, sel_onehot;
   logic [TW-1:0]            wd_q, wd_d;

   assign grant = (state_q == IDLE) && (|req_valid);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk     (PCLK),
      .resetn  (PRESETn),
      .req     (req_valid),
      .advance (grant),
      .gnt     (gnt)
   );

   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            win_addr  = req_addr[APB_AW*i +: APB_AW];
            win_wdata = req_wdata[APB_DW*i +: APB_DW];
            win_write = req_write[i];
         end
      end
      // Unpopulated slave indices mask to zero, which doubles as the decode-error flag.
      sel_onehot = SLV_MASK & (APB_MAX_SLV'(1) << win_addr[SEL_LSB+3:SEL_LSB]);
   end

   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      penable_d   = penable_q;
      psel_d      = psel_q;
      wd_d        = wd_q;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      case (state_q)
         IDLE: begin
            psel_d    = '0;
            penable_d = 1'b0;
            wd_d      = '0;
            if (grant) begin
               own_d = gnt;
               if (|sel_onehot) begin
                  state_d  = SETUP;
                  psel_d   = sel_onehot;
                  paddr_d  = win_addr;
                  pwdata_d = win_wdata;
                  pwrite_d = win_write;
               end else begin
                  rsp_valid_d = gnt;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               state_d     = IDLE;
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = own_q;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            end else if (TIMEOUT != 0 && wd_q == TW'(TIMEOUT - 1)) begin
               state_d     = IDLE;
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = own_q;
               rsp_err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         own_q       <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         penable_q   <= 1'b0;
         psel_q      <= '0;
         wd_q        <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         penable_q   <= penable_d;
         psel_q      <= psel_d;
         wd_q        <= wd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = (state_q == IDLE) ? gnt : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PWRITE    = pwrite_q;
   assign PENABLE   = penable_q;
   assign PSEL      = psel_q;
endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - self-checking bench for apb_arb_master
module tb_apb_arb_master;
   localparam int NR  = 2;
   localparam int NS  = 4;
   localparam int LSB = 12;
   localparam int TO  = 8;

   logic            PCLK = 1'b0;
   logic            PRESETn = 1'b0;
   logic [NR-1:0]   req_valid = '0, req_write = '0;
   logic [NR-1:0]   req_ready, rsp_valid;
   logic [NR*32-1:0] req_addr = '0, req_wdata = '0;
   logic [31:0]     rsp_rdata, PADDR, PWDATA;
   logic [31:0]     PRDATA = '0;
   logic            rsp_err, PWRITE, PENABLE;
   logic            PREADY = 1'b0;
   logic [15:0]     PSEL;
   int              n_cmp = 0, n_err = 0;

   apb_arb_master #(.NUM_REQ(NR), .NUM_SLV(NS), .SEL_LSB(LSB), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
      .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #500000;
      $display("FAIL sim_timeout: bench did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_psel"}, 32'(PSEL), 32'h0);
      chk({tag, "_pen"}, 32'(PENABLE), 32'h0);
      chk({tag, "_paddr"}, PADDR, 32'h0);
      chk({tag, "_pwdata"}, PWDATA, 32'h0);
      chk({tag, "_pwrite"}, 32'(PWRITE), 32'h0);
      chk({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_rsperr"}, 32'(rsp_err), 32'h0);
      chk({tag, "_rdata"}, rsp_rdata, 32'h0);
      chk({tag, "_rdy"}, 32'(req_ready), 32'h0);
   endtask

   // One transfer by a single requester; expectations come from the decode/wait/timeout rules.
   task automatic xfer(input int r, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int nwait, input logic [31:0] rdat);
      int          sidx, cyc, en_cnt, exp_en;
      bit          dec_ok, exp_err;
      logic [31:0] exp_psel, exp_rdata;
      sidx      = int'((addr >> LSB) & 32'hF);
      dec_ok    = sidx < NS;
      exp_psel  = dec_ok ? (32'h1 << sidx) : 32'h0;
      exp_err   = !dec_ok || (nwait >= TO);
      exp_en    = !dec_ok ? 0 : ((nwait + 1 > TO) ? TO : nwait + 1);
      exp_rdata = (exp_err || wr) ? 32'h0 : rdat;

      @(negedge PCLK);
      req_valid                = '0;
      req_valid[r]             = 1'b1;
      req_write[r]             = wr;
      req_addr[32*r +: 32]     = addr;
      req_wdata[32*r +: 32]    = wdata;
      PREADY                   = 1'b1;
      #1;
      cyc = 0;
      while (req_ready[r] !== 1'b1 && cyc < 20) begin
         @(negedge PCLK);
         #1;
         cyc++;
      end
      chk("grant", 32'(req_ready), 32'h1 << r);

      @(negedge PCLK);
      req_valid = '0;
      if (!dec_ok) begin
         chk("dec_psel", 32'(PSEL), 32'h0);
         chk("dec_pen", 32'(PENABLE), 32'h0);
         chk("dec_rspv", 32'(rsp_valid), 32'h1 << r);
         chk("dec_err", 32'(rsp_err), 32'h1);
         chk("dec_rdata", rsp_rdata, 32'h0);
         PREADY = 1'b0;
         return;
      end
      chk("setup_psel", 32'(PSEL), exp_psel);
      chk("setup_pen", 32'(PENABLE), 32'h0);
      chk("setup_paddr", PADDR, addr);
      chk("setup_pwrite", 32'(PWRITE), 32'(wr));
      if (wr) chk("setup_pwdata", PWDATA, wdata);

      en_cnt = 0;
      @(negedge PCLK);
      while (PENABLE === 1'b1 && en_cnt < 20) begin
         chk("acc_psel", 32'(PSEL), exp_psel);
         PREADY = (en_cnt == nwait);
         PRDATA = PREADY ? rdat : $urandom;
         en_cnt++;
         @(negedge PCLK);
      end
      PREADY = 1'b0;
      chk("pen_cycles", 32'(en_cnt), 32'(exp_en));
      chk("rsp_valid", 32'(rsp_valid), 32'h1 << r);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("end_psel", 32'(PSEL), 32'h0);
   endtask

   initial begin
      int          order[$], gcyc[$];
      bit          busy[2], drop[2];
      int          left[2];
      int          done, r, sidx, nwait;
      bit          wr;
      logic [31:0] addr;

      repeat (3) @(negedge PCLK);
      chk_all_zero("reset");
      PRESETn = 1'b1;

      xfer(0, 1'b1, 32'h0000_3010, 32'hA5A5_0001, 0, 32'h0);
      xfer(1, 1'b0, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF);

      // Contention: both requesters keep asking; expect strict alternation at 3-cycle spacing.
      busy = '{0, 0};
      drop = '{0, 0};
      left = '{2, 2};
      done = 0;
      req_write = '1;
      req_addr  = {32'h0000_2008, 32'h0000_0004};
      req_wdata = {$urandom, $urandom};
      PREADY = 1'b1;
      for (int cyc = 0; cyc < 80 && done < 4; cyc++) begin
         @(negedge PCLK);
         chk("one_xfer", 32'($onehot0(PSEL)), 32'h1);
         for (int i = 0; i < 2; i++) begin
            if (drop[i]) begin
               req_valid[i] = 1'b0;
               drop[i] = 1'b0;
            end
            if (rsp_valid[i]) begin
               busy[i] = 1'b0;
               done++;
               chk("cont_err", 32'(rsp_err), 32'h0);
            end
            if (!busy[i] && left[i] > 0) req_valid[i] = 1'b1;
         end
         #1;
         for (int i = 0; i < 2; i++) begin
            if (req_ready[i]) begin
               order.push_back(i);
               gcyc.push_back(cyc);
               busy[i] = 1'b1;
               drop[i] = 1'b1;
               left[i]--;
            end
         end
      end
      req_valid = '0;
      PREADY = 1'b0;
      chk("cont_done", 32'(done), 32'd4);
      chk("cont_grants", 32'(order.size()), 32'd4);
      for (int k = 0; k < order.size(); k++) begin
         chk("cont_order", 32'(order[k]), 32'(k % 2));
         if (k > 0) chk("cont_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
      end

      xfer(0, 1'b1, 32'h0000_5000, 32'h1234_5678, 0, 32'h0);
      xfer(1, 1'b0, 32'h0000_2000, 32'h0, 20, 32'hCAFE_F00D);

      // Reset during ACCESS, then a clean transfer.
      @(negedge PCLK);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[31:0] = 32'h0000_2040;
      #1;
      chk("rst_grant", 32'(req_ready), 32'h1);
      @(negedge PCLK);
      req_valid = '0;
      @(negedge PCLK);
      chk("rst_in_access", 32'(PENABLE), 32'h1);
      PRESETn = 1'b0;
      @(negedge PCLK);
      chk_all_zero("midrst");
      PRESETn = 1'b1;
      PREADY = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge PCLK);
         chk("midrst_norsp", 32'(rsp_valid), 32'h0);
      end
      PREADY = 1'b0;
      xfer(0, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0BAD_C0DE);

      for (int t = 0; t < 16; t++) begin
         r     = int'($urandom_range(0, 1));
         wr    = 1'($urandom_range(0, 1));
         sidx  = int'($urandom_range(0, 6));
         addr  = ($urandom & 32'hFFFF_0FFC) | (32'(sidx) << LSB);
         nwait = ($urandom_range(0, 5) == 0) ? 10 : int'($urandom_range(0, 3));
         xfer(r, wr, addr, $urandom, nwait, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
